// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the AHB-Lite bus arbiter and its round-robin picker.
package ahb_arb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam int BEAT_CNT_W = 8;
  localparam int PERF_CNT_W = 32;

  // LOCKED mirrors lock_hold: the owner is inside an HLOCK sequence.
  typedef enum logic {
    ARB_OWN    = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic beat_accepted(input logic [1:0] htrans);
    return (htrans == NONSEQ) || (htrans == SEQ);
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin picker: first set request searching upward from ptr_i
// (inclusive) with wrap-around. Callers exclude the current owner by masking req_i.
module arb_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotating a doubled copy puts ptr_i at bit 0, so a plain priority scan does the wrap.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    int sum;
    // NOTE: every output gets a default before the scan so no path leaves a latch.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = 0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_rot[k]) begin
        sum = int'(ptr_i) + k;
        if (sum >= N) sum = sum - N;
        valid_o = 1'b1;
        idx_o   = IDX_W'(sum);
      end
    end
    if (valid_o) grant_o = N'(1) << idx_o;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite address-phase arbiter with HLOCK sequences and a per-grant beat cap.
// Define ARB_PERF_CNT_EN to add per-master accepted-beat and wait-cycle counters.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MAX_BEATS      = 16,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_MASTERS-1:0]            i_req,
  input  logic [NUM_MASTERS-1:0]            i_hlock,
  input  logic [1:0]                        i_htrans,
  input  logic                              i_hready,
`ifdef ARB_PERF_CNT_EN
  input  logic                              i_cnt_clr,
  output logic [NUM_MASTERS*PERF_CNT_W-1:0] o_beat_cnt,
  output logic [NUM_MASTERS*PERF_CNT_W-1:0] o_wait_cnt,
`endif
  output logic [NUM_MASTERS-1:0]            o_hgrant,
  output logic [MIDX_W-1:0]                 o_hmaster,
  output logic [MIDX_W-1:0]                 o_hmaster_data,
  output logic                              o_data_valid,
  output logic                              o_hmastlock
);

  localparam logic [MIDX_W-1:0]      DEFAULT_IDX   = MIDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [BEAT_CNT_W-1:0]  CNT_MAX       = BEAT_CNT_W'(MAX_BEATS);

  arb_state_e                state_q, state_d;
  logic [MIDX_W-1:0]         owner_q, owner_d;
  logic [NUM_MASTERS-1:0]    grant_q, grant_d;
  logic [BEAT_CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [MIDX_W-1:0]         hmaster_data_q;
  logic                      data_valid_q;

  logic                      beat;
  logic                      owner_hlock;
  logic                      lock_active;
  logic                      cap_hit;
  logic                      do_switch;
  logic [BEAT_CNT_W:0]       cnt_inc;
  logic [NUM_MASTERS-1:0]    owner_mask;
  logic [NUM_MASTERS-1:0]    other_req;
  logic [NUM_MASTERS-1:0]    pick_grant;
  logic [MIDX_W-1:0]         pick_idx;
  logic                      pick_valid;

  assign owner_mask = NUM_MASTERS'(1) << owner_q;
  assign other_req  = i_req & ~owner_mask;

  arb_rr_select #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_rr_select (
    .req_i   (other_req),
    .ptr_i   (owner_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    beat        = beat_accepted(i_htrans);
    owner_hlock = i_hlock[owner_q];
    // A locked beat protects itself even before lock_hold has been registered.
    lock_active = (state_q == ARB_LOCKED) || (beat && owner_hlock);
    cnt_inc     = {1'b0, beat_cnt_q} + (BEAT_CNT_W + 1)'(1);
    cap_hit     = beat && (cnt_inc >= {1'b0, CNT_MAX});
    do_switch   = pick_valid && !lock_active &&
                  ((i_htrans == IDLE) || cap_hit || !i_req[owner_q]);
  end

  always_comb begin
    owner_d    = owner_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    state_d    = state_q;

    if (do_switch) begin
      owner_d    = pick_idx;
      grant_d    = pick_grant;
      beat_cnt_d = '0;
    end else if (beat) begin
      // At the cap a locked owner saturates; an unchallenged owner starts a fresh grant.
      if (cap_hit) beat_cnt_d = lock_active ? CNT_MAX : '0;
      else         beat_cnt_d = cnt_inc[BEAT_CNT_W-1:0];
    end

    unique case (i_htrans)
      IDLE:        if (!owner_hlock) state_d = ARB_OWN;
      BUSY:        state_d = state_q;
      NONSEQ, SEQ: state_d = owner_hlock ? ARB_LOCKED : ARB_OWN;
      default:     state_d = state_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q        <= ARB_OWN;
      owner_q        <= DEFAULT_IDX;
      grant_q        <= DEFAULT_GRANT;
      beat_cnt_q     <= '0;
      hmaster_data_q <= DEFAULT_IDX;
      data_valid_q   <= 1'b0;
    end else if (i_hready) begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      grant_q        <= grant_d;
      beat_cnt_q     <= beat_cnt_d;
      hmaster_data_q <= owner_q;
      data_valid_q   <= beat;
    end
  end

  assign o_hgrant       = grant_q;
  assign o_hmaster      = owner_q;
  assign o_hmaster_data = hmaster_data_q;
  assign o_data_valid   = data_valid_q;
  assign o_hmastlock    = owner_hlock && (i_htrans != IDLE);

`ifdef ARB_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] PERF_SAT = '1;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_perf
    logic [PERF_CNT_W-1:0] beat_perf_q;
    logic [PERF_CNT_W-1:0] wait_perf_q;

    always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
        beat_perf_q <= '0;
        wait_perf_q <= '0;
      end else if (i_hready) begin
        if (beat && (owner_q == MIDX_W'(m)) && (beat_perf_q != PERF_SAT))
          beat_perf_q <= beat_perf_q + PERF_CNT_W'(1);
        if (i_req[m] && !grant_q[m] && (wait_perf_q != PERF_SAT))
          wait_perf_q <= wait_perf_q + PERF_CNT_W'(1);
      end
    end

    assign o_beat_cnt[m*PERF_CNT_W +: PERF_CNT_W] = beat_perf_q;
    assign o_wait_cnt[m*PERF_CNT_W +: PERF_CNT_W] = wait_perf_q;
  end
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model of ownership, beat count and lock.
module tb_ahb_bus_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  hlock;
  logic [1:0]    htrans;
  logic          hready;
  logic [N-1:0]  hgrant;
  logic [1:0]    hmaster;
  logic [1:0]    hmaster_data;
  logic          data_valid;
  logic          hmastlock;

`ifdef ARB_PERF_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [N*32-1:0]   beat_cnt_o;
  logic [N*32-1:0]   wait_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state, expressed as plain integers.
  int m_owner, m_cnt, m_downer;
  bit m_lock, m_dvalid;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .MAX_BEATS      (MAXB),
    .DEFAULT_MASTER (0)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_hlock        (hlock),
    .i_htrans       (htrans),
    .i_hready       (hready),
`ifdef ARB_PERF_CNT_EN
    .i_cnt_clr      (cnt_clr),
    .o_beat_cnt     (beat_cnt_o),
    .o_wait_cnt     (wait_cnt_o),
`endif
    .o_hgrant       (hgrant),
    .o_hmaster      (hmaster),
    .o_hmaster_data (hmaster_data),
    .o_data_valid   (data_valid),
    .o_hmastlock    (hmastlock)
  );

  task automatic model_step();
    bit beat, locked, capped, sw;
    int winner, c;
    if (rst) begin
      m_owner = 0; m_cnt = 0; m_lock = 0; m_downer = 0; m_dvalid = 0;
      return;
    end
    if (!hready) return;
    beat   = (htrans == 2'b10) || (htrans == 2'b11);
    winner = -1;
    for (int k = 1; k < N; k++) begin
      c = (m_owner + k) % N;
      if (winner < 0 && req[c]) winner = c;
    end
    locked = m_lock || (beat && hlock[m_owner]);
    capped = beat && (m_cnt + 1 >= MAXB);
    sw     = (winner >= 0) && !locked && (htrans == 2'b00 || capped || !req[m_owner]);
    m_downer = m_owner;
    m_dvalid = beat;
    if (beat) m_lock = hlock[m_owner];
    else if (htrans == 2'b00 && !hlock[m_owner]) m_lock = 0;
    if (sw) begin
      m_owner = winner;
      m_cnt   = 0;
    end else if (beat) begin
      if (m_cnt + 1 >= MAXB) m_cnt = locked ? MAXB : 0;
      else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [N-1:0] g;
    g = 3'b001 << m_owner;
    return {2'(m_owner), g, 2'(m_downer), m_dvalid, hlock[m_owner] & (htrans != 2'b00)};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {hmaster, hgrant, hmaster_data, data_valid, hmastlock};
  endfunction

  task automatic test_reset();
    logic [8:0] rst_vec;
    rst_vec = {2'd0, 3'b001, 2'd0, 1'b0, 1'b0};
    rst = 1; req = '0; hlock = '0; htrans = 2'b00; hready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec() !== rst_vec) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %b expected %b", i, obs_vec(), rst_vec);
      end
    end
    checks++;
    if (dut.beat_cnt_q !== 8'd0) begin
      errors++;
      $display("FAIL reset_beat_cnt: got %0d expected 0", dut.beat_cnt_q);
    end
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_vec() !== rst_vec) begin
        errors++;
        $display("FAIL reset_park cycle %0d: got %b expected %b", i, obs_vec(), rst_vec);
      end
    end
  endtask

  task automatic test_handover();
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || hmaster !== 2'd0) begin
        errors++;
        $display("FAIL handover_burst beat %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    htrans = 2'b00;
    tick();
    checks++;
    if (hmaster !== 2'd1 || hgrant !== 3'b010 || hmaster_data !== 2'd0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL handover_switch: got m=%0d g=%b d=%0d v=%b expected m=1 g=010 d=0 v=0",
               hmaster, hgrant, hmaster_data, data_valid);
    end
    htrans = 2'b10;
    tick();
    checks++;
    if (hmaster_data !== 2'd1 || data_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL handover_data_owner: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_beat_cap();
    rst = 1; tick(); rst = 0;
    req = 3'b010; htrans = 2'b00;
    tick();
    checks++;
    if (hmaster !== 2'd1) begin
      errors++;
      $display("FAIL cap_setup: got owner %0d expected 1", hmaster);
    end
    req = 3'b011;
    for (int i = 1; i <= MAXB; i++) begin
      htrans = (i == 1) ? 2'b10 : 2'b11;
      tick();
      checks++;
      if (hmaster !== ((i == MAXB) ? 2'd0 : 2'd1) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cap_switch beat %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    req = 3'b010; htrans = 2'b00;
    tick();
    htrans = 2'b11;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (hmaster !== 2'd1 || obs_vec() !== exp_vec() || dut.beat_cnt_q !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL cap_sole_owner beat %0d: got %b cnt %0d expected %b cnt %0d",
                 i, obs_vec(), dut.beat_cnt_q, exp_vec(), m_cnt);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] cnt_before;
    cnt_before = 8'(m_cnt);
    req = 3'b011; htrans = 2'b00; hready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hmaster !== 2'd1 || hgrant !== 3'b010 || dut.beat_cnt_q !== cnt_before) begin
        errors++;
        $display("FAIL wait_frozen cycle %0d: got m=%0d g=%b cnt=%0d expected m=1 g=010 cnt=%0d",
                 i, hmaster, hgrant, dut.beat_cnt_q, cnt_before);
      end
    end
    hready = 1;
    tick();
    checks++;
    if (hmaster !== 2'd0 || hgrant !== 3'b001 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL wait_release: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lock();
    req = 3'b011; hlock = 3'b001;
    for (int i = 0; i < 20; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
      checks++;
      if (hmaster !== 2'd0 || hmastlock !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_hold beat %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (dut.beat_cnt_q !== 8'(MAXB)) begin
      errors++;
      $display("FAIL lock_saturate: got %0d expected %0d", dut.beat_cnt_q, MAXB);
    end
    htrans = 2'b00; hlock = 3'b000;
    tick();
    checks++;
    if (hmaster !== 2'd0 || hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL lock_unlock_idle: got m=%0d lock=%b expected m=0 lock=0", hmaster, hmastlock);
    end
    tick();
    checks++;
    if (hmaster !== 2'd1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL lock_release_switch: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    req = 3'b010; hlock = '0;
    for (int i = 0; i < 7; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
    end
    checks++;
    if (hmaster !== 2'd1 || dut.beat_cnt_q !== 8'd7) begin
      errors++;
      $display("FAIL midrst_setup: got m=%0d cnt=%0d expected m=1 cnt=7", hmaster, dut.beat_cnt_q);
    end
    rst = 1; htrans = 2'b11;
    tick();
    rst = 0;
    checks++;
    if (hmaster !== 2'd0 || hgrant !== 3'b001 || data_valid !== 1'b0 || dut.beat_cnt_q !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: got m=%0d g=%b v=%b cnt=%0d expected m=0 g=001 v=0 cnt=0",
               hmaster, hgrant, data_valid, dut.beat_cnt_q);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (beat_cnt_o !== '0) begin
      errors++;
      $display("FAIL perf_reset: got %h expected 0", beat_cnt_o);
    end
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
    end
    checks++;
    if (beat_cnt_o[31:0] !== 32'd3) begin
      errors++;
      $display("FAIL perf_beats: got %0d expected 3", beat_cnt_o[31:0]);
    end
`endif
  endtask

  task automatic test_random();
    bit busy_mode;
    for (int i = 0; i < 2000; i++) begin
      busy_mode = ((i / 200) % 2) == 1;
      rst = ($urandom_range(0, 199) == 0);
      if (!busy_mode || $urandom_range(0, 19) == 0) req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) hlock = N'($urandom_range(0, 7));
      if (busy_mode) htrans = ($urandom_range(0, 19) == 0) ? 2'b00 : 2'b11;
      else           htrans = 2'($urandom_range(0, 3));
      hready = ($urandom_range(0, 4) != 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || dut.beat_cnt_q !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b cnt %0d expected %b cnt %0d",
                 i, obs_vec(), dut.beat_cnt_q, exp_vec(), m_cnt);
      end
    end
    rst = 0; hready = 1; htrans = 2'b00; hlock = '0; req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation exceeded its time limit");
  end

  initial begin
    test_reset();
    test_handover();
    test_beat_cap();
    test_wait_states();
    test_lock();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Round-robin address-phase arbiter for the shared AHB-Lite fabric in the TX/RX subsystem. It decides which master owns the bus: the AHB-to-AHB bridge (master 0), the gp_engine DMA (master 1), or further masters when NUM_MASTERS is larger. It drives the owner index that the interconnect's address and write-data muxes use. It enforces HLOCK sequences and a per-grant beat cap, so a long gp_engine transfer cannot starve the CPU bridge.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8).
MAX_BEATS, 16, accepted beats per grant before forced re-arbitration if another master is requesting (1..255).
DEFAULT_MASTER, 0, owner after reset.
MIDX_W, $clog2(NUM_MASTERS) (min 1), width of master indices.

Ports:
i_clk  in  1  bus clock.
i_rst  in  1  synchronous, active-high reset.
i_req  in  NUM_MASTERS  per-master request (htrans[1] of each master, or a pending-request flag).
i_hlock  in  NUM_MASTERS  per-master HLOCK.
i_htrans  in  2  HTRANS of the current address-phase owner (already muxed).
i_hready  in  1  fabric HREADY (selected slave HREADYOUT).
o_hgrant  out  NUM_MASTERS  one-hot address-phase grant.
o_hmaster  out  MIDX_W  address-phase owner index.
o_hmaster_data  out  MIDX_W  data-phase owner index, used for read-data and response routing.
o_data_valid  out  1  a data phase is in progress.
o_hmastlock  out  1  the current address phase is locked.

Behaviour:
- All state is updated only on a rising i_clk edge when i_hready=1. When i_hready=0, every register and output holds.
- Reset values (i_rst=1 at the clock edge):
  - o_hmaster = DEFAULT_MASTER; o_hgrant = one-hot(DEFAULT_MASTER); o_hmaster_data = DEFAULT_MASTER.
  - o_data_valid = 0; o_hmastlock = 0; beat_cnt = 0; lock_hold = 0.
  - Reset overrides any transfer in progress; no completion is emitted.
- A beat is accepted when i_hready=1 and i_htrans is NONSEQ(10) or SEQ(11). BUSY(01) keeps ownership but is not counted as a beat.
- States:
  - OWN: the owner holds the bus.
  - LOCKED: the owner has asserted HLOCK.
  - No separate idle state: when there are no requests, the bus stays parked on the last owner.
- Re-arbitration is evaluated at each i_hready=1 edge. A switch happens if any of these is true:
  - (a) i_htrans=IDLE and another master is requesting;
  - (b) beat_cnt reaches MAX_BEATS after this beat, another master is requesting, and lock is not active;
  - (c) i_req[owner]=0 and another master is requesting.
- Winner selection: the first requester searching from owner+1 upward with wrap-around, excluding the current owner. If the owner is the only requester, it keeps the bus and beat_cnt resets to 0 at the cap.
- Handover latency: a request sampled at edge N takes ownership at edge N (the new o_hmaster is valid in cycle N+1). This gives one address-phase cycle of latency.
- beat_cnt:
  - Increments on each accepted beat.
  - Clears to 0 on an owner change.
  - Saturates at MAX_BEATS while locked.
  - Width is 8 bits.
- Lock:
  - lock_hold is set when a beat is accepted with i_hlock[owner]=1, and cleared on an accepted beat or IDLE with i_hlock[owner]=0.
  - While lock_hold=1, no switch happens, regardless of the cap or other requests.
  - o_hmastlock = i_hlock[o_hmaster] & (i_htrans != IDLE), combinational.
- Data phase: at each i_hready=1 edge, o_hmaster_data <= o_hmaster and o_data_valid <= (beat accepted). A transfer's data phase therefore always reports the master that issued its address, even across a handover.
- Simultaneous requests on the first edge after reset, with owner 0 idle: master 1 wins.

Optional Feature:
ARB_PERF_CNT_EN. When defined, the block adds:
- input i_cnt_clr (1 bit);
- output o_beat_cnt (NUM_MASTERS*32 bits): per-master saturating counts of accepted beats (saturating at 0xFFFF_FFFF);
- output o_wait_cnt (NUM_MASTERS*32 bits): per-master saturating counts of cycles spent requesting without a grant.

Counter rules when defined:
- All counters reset to 0 on i_rst.
- i_cnt_clr clears all counters synchronously and takes priority over increments in the same cycle.

When not defined, these ports and counters are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS localparams: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - BEAT_CNT_W=8;
  - PERF_CNT_W=32.
- Sub-module arb_rr_select: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the one-hot result, the index and a valid flag. It is reusable by the DSP register arbiter.

Test Plan:
1. Reset hold: i_rst=1 for 3 cycles, then released with no requests -> o_hmaster=0, o_hgrant=2'b01, o_data_valid=0; the state holds for 10 cycles.
2. Round-robin handover: i_req=2'b11 with owner 0 issuing a 4-beat burst, then IDLE -> switch to master 1 at the edge where IDLE is sampled; o_hmaster_data stays 0 for the final data phase, then becomes 1.
3. Beat cap: MAX_BEATS=16, master 1 streams SEQ continuously while i_req[0]=1 -> grant moves to 0 after exactly the 16th accepted beat; with i_req[0]=0, master 1 keeps the bus for 40 beats.
4. Wait states: i_hready=0 for 5 cycles during the handover edge -> o_hmaster, o_hgrant and beat_cnt frozen; switch completes on the first i_hready=1 edge.
5. Lock: master 0 asserts i_hlock for 20 beats with i_req[1]=1 -> no switch and o_hmastlock=1 throughout; switch to 1 on the first edge after the unlocked IDLE.
6. Mid-burst reset: i_rst=1 while master 1 owns the bus at beat_cnt=7 -> next cycle o_hmaster=0, o_data_valid=0, beat_cnt=0. With ARB_PERF_CNT_EN: o_beat_cnt==0 after reset, and increments to 3 after 3 accepted beats.
